// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the FSM encoding, owner codes, default geometry and the address checker.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_DATA_W = 64;

  // An access is rejected when it is not doubleword aligned or falls past the array.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] depth);
    addr_err = (addr[2:0] != 3'd0) || ((addr >> 3) >= depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (pipeline MEM stage and loader/debug port) for the single
// data-memory port, with address checking, mem_ack timeout and cpu stall generation.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = 64,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  output logic                     cpu_stall,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic [DATA_W-1:0]        dbg_rdata,
  output logic                     dbg_ack,
  output logic                     dbg_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_idx,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WC_W  = $clog2(MAX_WAIT + 1);
  localparam int TC_W  = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic                r_busy;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [WC_W-1:0]     r_wait_cnt;
  logic [TC_W-1:0]     r_tmo_cnt;
  logic                r_mem_req;
  logic                r_cpu_ack;
  logic                r_cpu_err;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_dbg_ack;
  logic                r_dbg_err;
  logic [DATA_W-1:0]   r_dbg_rdata;

  state_t              w_next_state;
  logic                w_grant;
  logic                w_grant_dbg;
  logic                w_addr_err;
  logic                w_resp;
  logic                w_resp_err;
  logic [DATA_W-1:0]   w_resp_data;

  assign w_addr_err = addr_err(64'(r_addr), 64'(DEPTH));
  assign w_resp     = (w_next_state == RESP);

  // Next-state, grant decision and response payload.
  // IDLE with r_busy set is the one-cycle address-check slot after a grant.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_dbg  = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_data  = '0;
    case (r_state)
      IDLE: begin
        if (!r_busy) begin
          if (cpu_req && dbg_req) begin
            w_grant     = 1'b1;
            w_grant_dbg = (r_wait_cnt == WC_W'(MAX_WAIT));
          end else if (cpu_req) begin
            w_grant     = 1'b1;
          end else if (dbg_req) begin
            w_grant     = 1'b1;
            w_grant_dbg = 1'b1;
          end else begin
            w_grant     = 1'b0;
          end
        end else if (w_addr_err) begin
          w_next_state = RESP;
          w_resp_err   = 1'b1;
        end else begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        // mem_ack takes priority over the timeout terminal count
        if (mem_ack) begin
          w_next_state = RESP;
          w_resp_data  = r_we ? '0 : mem_rdata;
        end else if (r_tmo_cnt == TC_W'(TIMEOUT - 1)) begin
          w_next_state = RESP;
          w_resp_err   = 1'b1;
        end else begin
          w_next_state = ACCESS;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, latched payload, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_err   <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      r_state   <= w_next_state;
      r_busy    <= w_grant;
      r_mem_req <= (w_next_state == ACCESS);
      r_tmo_cnt <= ((r_state == ACCESS) && (w_next_state == ACCESS)) ?
                   r_tmo_cnt + TC_W'(1) : '0;

      if (w_grant) begin
        r_owner <= w_grant_dbg ? OWN_DBG : OWN_CPU;
        r_we    <= w_grant_dbg ? dbg_we : cpu_we;
        r_addr  <= w_grant_dbg ? dbg_addr : cpu_addr;
        r_wdata <= w_grant_dbg ? dbg_wdata : cpu_wdata;
      end

      // Count cpu grants that made a waiting dbg requester sit out
      if (w_grant && w_grant_dbg) begin
        r_wait_cnt <= '0;
      end else if (w_grant && dbg_req) begin
        r_wait_cnt <= (r_wait_cnt == WC_W'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + WC_W'(1);
      end else if ((r_state == IDLE) && !dbg_req) begin
        r_wait_cnt <= '0;
      end

      r_cpu_ack   <= w_resp && (r_owner == OWN_CPU);
      r_cpu_err   <= w_resp && (r_owner == OWN_CPU) && w_resp_err;
      r_cpu_rdata <= (w_resp && (r_owner == OWN_CPU)) ? w_resp_data : '0;
      r_dbg_ack   <= w_resp && (r_owner == OWN_DBG);
      r_dbg_err   <= w_resp && (r_owner == OWN_DBG) && w_resp_err;
      r_dbg_rdata <= (w_resp && (r_owner == OWN_DBG)) ? w_resp_data : '0;
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign cpu_err   = r_cpu_err;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_err   = r_dbg_err;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_we & r_mem_req;
  assign mem_idx   = r_addr[IDX_W+2:3];
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a memory device model plus a transaction-level
// reference model checked on every falling edge, and literal expectations per vector.
module tb_dmem_arbiter;

  localparam int DEPTH    = 1024;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 64;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 16;
  localparam int IDX_W    = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack, cpu_err, cpu_stall;
  logic              dbg_req = 1'b0, dbg_we = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack, dbg_err;
  logic              mem_req, mem_we, mem_ack;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic ack_en   = 1'b1;
  logic late_ack = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  function automatic logic [63:0] pat(input int i);
    pat = (i == 2) ? 64'd1 : (64'hC0DE_0000_0000_0000 | 64'(i));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory device: combinational ack when enabled, plus an injectable stray ack.
  logic [63:0] dev_mem [0:DEPTH-1];
  always_comb begin
    mem_ack   = (mem_req & ack_en) | late_ack;
    mem_rdata = dev_mem[mem_idx];
  end
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) dev_mem[i] <= pat(i);
    end else if (mem_req && mem_ack && mem_we) begin
      dev_mem[mem_idx] <= mem_wdata;
    end
  end

  // Reference model and compare process.
  logic [63:0]      ref_mem [0:DEPTH-1];
  int               m_wait = 0;
  int               seen_n = 0;
  logic [IDX_W-1:0] seen_idx = '0, last_idx = '0;
  logic             seen_we = 1'b0;
  logic [63:0]      seen_wdata = '0, last_wdata = '0;

  always @(negedge clock) begin : compare
    logic [63:0]      a, wd, exp_rd;
    logic             we, ad_err, exp_err, exp_dbg;
    int               exp_n;
    logic [IDX_W-1:0] ix;
    chk("stall", 64'(cpu_stall), 64'(cpu_req & ~cpu_ack));
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
      m_wait = 0;
      seen_n = 0;
      chk("rst_ctrl", 64'({cpu_ack, dbg_ack, cpu_err, dbg_err, mem_req, mem_we}), 64'd0);
      chk("rst_rdata", cpu_rdata | dbg_rdata, 64'd0);
    end else begin
      if (mem_req) begin
        if (seen_n > 0) chk("mem_idx_stable", 64'(mem_idx), 64'(seen_idx));
        seen_idx   = mem_idx;
        seen_we    = mem_we;
        seen_wdata = mem_wdata;
        last_idx   = mem_idx;
        last_wdata = mem_wdata;
        seen_n++;
      end
      if (cpu_ack || dbg_ack) begin
        chk("ack_excl", 64'(cpu_ack & dbg_ack), 64'd0);
        chk("ack_has_req", 64'(dbg_ack ? dbg_req : cpu_req), 64'd1);
        if (cpu_req && dbg_req) exp_dbg = (m_wait == MAX_WAIT);
        else exp_dbg = dbg_req;
        chk("owner", 64'(dbg_ack), 64'(exp_dbg));
        a  = dbg_ack ? dbg_addr : cpu_addr;
        we = dbg_ack ? dbg_we : cpu_we;
        wd = dbg_ack ? dbg_wdata : cpu_wdata;
        ad_err  = (a[2:0] != 3'd0) || ((a >> 3) >= 64'(DEPTH));
        exp_err = ad_err || !ack_en;
        exp_n   = ad_err ? 0 : (ack_en ? 1 : TIMEOUT);
        ix      = a[IDX_W+2:3];
        exp_rd  = (!exp_err && !we) ? ref_mem[ix] : 64'd0;
        chk("mem_req_cycles", 64'(seen_n), 64'(exp_n));
        if (seen_n > 0) begin
          chk("mem_idx", 64'(seen_idx), 64'(ix));
          chk("mem_we", 64'(seen_we), 64'(we));
          if (we) chk("mem_wdata", seen_wdata, wd);
        end
        chk("rdata", dbg_ack ? dbg_rdata : cpu_rdata, exp_rd);
        chk("err", 64'(dbg_ack ? dbg_err : cpu_err), 64'(exp_err));
        if (!exp_err && we) ref_mem[ix] = wd;
        if (exp_dbg) m_wait = 0;
        else if (dbg_req) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else m_wait = 0;
        seen_n = 0;
      end
    end
  end

  task automatic txn(input logic dbg, input logic we, input logic [63:0] addr,
                     input logic [63:0] wd, input int exp_lat, input string nm,
                     output logic [63:0] rd, output logic er);
    int   lat;
    logic got;
    @(negedge clock); #1;
    if (dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      got = dbg ? dbg_ack : cpu_ack;
    end
    rd = dbg ? dbg_rdata : cpu_rdata;
    er = dbg ? dbg_err : cpu_err;
    chk({nm, "_acked"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clock); #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench stalled");
  end

  initial begin : stim
    logic [63:0] rd;
    logic        er;
    logic [5:0]  seq;
    int          n, cyc, cnt;

    cpu_req = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    reset   = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(posedge clock);

    txn(1'b0, 1'b0, 64'h10, 64'd0, 3, "ld_0x10", rd, er);
    chk("ld_0x10_val", rd, 64'd1);
    chk("ld_0x10_err", 64'(er), 64'd0);

    txn(1'b0, 1'b1, 64'h1FF8, 64'hAB, 3, "st_0x1ff8", rd, er);
    chk("st_idx", 64'(last_idx), 64'd1023);
    chk("st_wdata", last_wdata, 64'hAB);
    chk("st_rdata", rd, 64'd0);
    txn(1'b0, 1'b0, 64'h1FF8, 64'd0, 3, "ld_0x1ff8", rd, er);
    chk("ld_0x1ff8_val", rd, 64'hAB);

    txn(1'b0, 1'b0, 64'h2000, 64'd0, 2, "ld_oob", rd, er);
    chk("ld_oob_err", 64'(er), 64'd1);
    chk("ld_oob_val", rd, 64'd0);
    txn(1'b0, 1'b0, 64'h4, 64'd0, 2, "ld_unal", rd, er);
    chk("ld_unal_err", 64'(er), 64'd1);

    txn(1'b1, 1'b1, 64'h100, 64'h1234, 3, "dbg_st", rd, er);
    txn(1'b0, 1'b0, 64'h100, 64'd0, 3, "ld_0x100", rd, er);
    chk("ld_0x100_val", rd, 64'h1234);

    // Both requesters held: four cpu grants, then dbg is forced in.
    @(negedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h18;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h20;
    seq = '0; n = 0; cyc = 0;
    while (n < 6 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      if (cpu_ack || dbg_ack) begin
        seq[n] = dbg_ack;
        n++;
      end
    end
    @(negedge clock); #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    chk("arb_count", 64'(n), 64'd6);
    chk("arb_order", 64'(seq), 64'(6'b010000));

    // Timeout, then a stray mem_ack that must be ignored.
    ack_en = 1'b0;
    txn(1'b0, 1'b0, 64'h30, 64'd0, 18, "tmo", rd, er);
    chk("tmo_err", 64'(er), 64'd1);
    ack_en   = 1'b1;
    late_ack = 1'b1;
    repeat (2) @(posedge clock);
    #1 late_ack = 1'b0;
    txn(1'b0, 1'b0, 64'h10, 64'd0, 3, "after_tmo", rd, er);
    chk("after_tmo_val", rd, 64'd1);
    chk("after_tmo_err", 64'(er), 64'd0);

    // Reset while dbg owns an outstanding access.
    ack_en = 1'b0;
    @(negedge clock); #1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h40;
    repeat (5) @(posedge clock);
    #1 chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
    @(negedge clock); #1;
    reset   = 1'b1;
    dbg_req = 1'b0;
    @(posedge clock); #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    @(negedge clock); #1;
    reset  = 1'b0;
    ack_en = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (cpu_ack || dbg_ack) cnt++;
    end
    chk("no_ack_after_rst", 64'(cnt), 64'd0);

    @(negedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h18;
    cyc = 0;
    while (!(cpu_ack || dbg_ack) && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("post_rst_owner_cpu", 64'(cpu_ack), 64'd1);
    chk("post_rst_latency", 64'(cyc), 64'd3);
    chk("post_rst_val", cpu_rdata, 64'd1);
    @(negedge clock); #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (4) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
